// File: rtl/ttt_pkg.sv
// Shared types and constants for the N x N, K-in-a-row game engine.
package ttt_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // Width of a cell index for an n x n board.
  function automatic int calc_iw(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational detector: is there a run of K set cells anywhere on one board
// (rows, columns, diagonals, anti-diagonals)?
module ttt_line_check #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic [N*N-1:0] board,
  output logic           win
);

  localparam int CELLS = N * N;

  // Four candidate runs start at each cell: right, down, down-right, down-left.
  logic [4*CELLS-1:0] runs_s;

  function automatic logic run_set(input logic [CELLS-1:0] b, input int start, input int stride);
    logic acc;
    acc = 1'b1;
    for (int k = 0; k < K; k++) begin
      acc = acc & b[start + k * stride];
    end
    return acc;
  endfunction

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int S = r * N + c;
      if (c + K <= N) begin : g_h
        assign runs_s[4*S+0] = run_set(board, S, 1);
      end else begin : g_nh
        assign runs_s[4*S+0] = 1'b0;
      end
      if (r + K <= N) begin : g_v
        assign runs_s[4*S+1] = run_set(board, S, N);
      end else begin : g_nv
        assign runs_s[4*S+1] = 1'b0;
      end
      if ((r + K <= N) && (c + K <= N)) begin : g_d
        assign runs_s[4*S+2] = run_set(board, S, N + 1);
      end else begin : g_nd
        assign runs_s[4*S+2] = 1'b0;
      end
      if ((r + K <= N) && (c >= K - 1)) begin : g_a
        assign runs_s[4*S+3] = run_set(board, S, N - 1);
      end else begin : g_na
        assign runs_s[4*S+3] = 1'b0;
      end
    end
  end

  assign win = |runs_s;

endmodule

// File: rtl/ttt_game_engine.sv
// Two-player N x N, K-in-a-row engine: move validation, board state, win/draw
// detection, per-turn timeout, alternating starter and saturating scores.
module ttt_game_engine
  import ttt_pkg::*;
#(
  parameter  int N       = 3,
  parameter  int K       = 3,
  parameter  int TIMEOUT = 0,
  parameter  int SCORE_W = 4,
  localparam int CELLS   = N * N,
  localparam int IW      = calc_iw(N),
  localparam int CW      = $clog2(N * N + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               restart,
  input  logic               move_valid,
  input  logic               move_player,
  input  logic [IW-1:0]      move_idx,
  output logic [CELLS-1:0]   board_p1,
  output logic [CELLS-1:0]   board_p2,
  output logic               turn,
  output logic               invalid,
  output logic               timeout,
  output logic [1:0]         result,
  output logic               game_over,
  output logic [CW-1:0]      move_count,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state_r, state_nx_s;
  logic [CELLS-1:0]   board_p1_r, board_p1_nx_s, board_p2_r, board_p2_nx_s;
  logic               turn_r, turn_nx_s, starter_r, starter_nx_s;
  logic               invalid_r, invalid_nx_s, timeout_r, timeout_nx_s;
  logic               game_over_r;
  logic [1:0]         result_r, result_nx_s;
  logic [CW-1:0]      move_count_r, move_count_nx_s;
  logic [SCORE_W-1:0] score_p1_r, score_p1_nx_s, score_p2_r, score_p2_nx_s;
  logic [TW-1:0]      tcnt_r, tcnt_nx_s;

  logic [CELLS-1:0]   cell_mask_s, board_sel_s;
  logic               idx_ok_s, free_s, accept_s, win_s;

  // An out-of-range index shifts the mask to zero, so the cell looks free;
  // idx_ok_s rejects it instead.
  assign cell_mask_s = {{(CELLS-1){1'b0}}, 1'b1} << move_idx;
  assign idx_ok_s    = int'(move_idx) < CELLS;
  assign free_s      = ((board_p1_r | board_p2_r) & cell_mask_s) == {CELLS{1'b0}};
  assign accept_s    = (state_r == PLAY) && move_valid && (move_player == turn_r)
                       && idx_ok_s && free_s;
  assign board_sel_s = turn_r ? board_p2_r : board_p1_r;

  ttt_line_check #(.N(N), .K(K)) u_line_check (
    .board (board_sel_s),
    .win   (win_s)
  );

  // Next-state, board, counter and score logic; restart overrides everything.
  always_comb begin
    state_nx_s      = state_r;
    board_p1_nx_s   = board_p1_r;
    board_p2_nx_s   = board_p2_r;
    turn_nx_s       = turn_r;
    starter_nx_s    = starter_r;
    invalid_nx_s    = 1'b0;
    timeout_nx_s    = 1'b0;
    result_nx_s     = result_r;
    move_count_nx_s = move_count_r;
    score_p1_nx_s   = score_p1_r;
    score_p2_nx_s   = score_p2_r;
    tcnt_nx_s       = tcnt_r;
    if (restart) begin
      board_p1_nx_s   = {CELLS{1'b0}};
      board_p2_nx_s   = {CELLS{1'b0}};
      move_count_nx_s = {CW{1'b0}};
      result_nx_s     = RES_NONE;
      tcnt_nx_s       = {TW{1'b0}};
      starter_nx_s    = ~starter_r;
      turn_nx_s       = ~starter_r;
      state_nx_s      = PLAY;
    end else begin
      if (move_valid && !accept_s) begin
        invalid_nx_s = 1'b1;
      end else begin
        invalid_nx_s = 1'b0;
      end
      case (state_r)
        PLAY: begin
          if (accept_s) begin
            if (turn_r) begin
              board_p2_nx_s = board_p2_r | cell_mask_s;
            end else begin
              board_p1_nx_s = board_p1_r | cell_mask_s;
            end
            move_count_nx_s = move_count_r + CW'(1);
            tcnt_nx_s       = {TW{1'b0}};
            state_nx_s      = CHECK;
          end else if (TIMEOUT > 0) begin
            if (tcnt_r == TW'(TIMEOUT - 1)) begin
              turn_nx_s    = ~turn_r;
              timeout_nx_s = 1'b1;
              tcnt_nx_s    = {TW{1'b0}};
            end else begin
              tcnt_nx_s = tcnt_r + TW'(1);
            end
          end else begin
            tcnt_nx_s = {TW{1'b0}};
          end
        end
        CHECK: begin
          if (win_s) begin
            result_nx_s = turn_r ? RES_P2 : RES_P1;
            if (turn_r) begin
              if (score_p2_r != {SCORE_W{1'b1}}) begin
                score_p2_nx_s = score_p2_r + SCORE_W'(1);
              end else begin
                score_p2_nx_s = score_p2_r;
              end
            end else begin
              if (score_p1_r != {SCORE_W{1'b1}}) begin
                score_p1_nx_s = score_p1_r + SCORE_W'(1);
              end else begin
                score_p1_nx_s = score_p1_r;
              end
            end
            state_nx_s = DONE;
          end else if (move_count_r == CW'(CELLS)) begin
            result_nx_s = RES_DRAW;
            state_nx_s  = DONE;
          end else begin
            turn_nx_s  = ~turn_r;
            state_nx_s = PLAY;
          end
        end
        DONE: begin
          state_nx_s = DONE;
        end
        default: begin
          state_nx_s = PLAY;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= PLAY;
      board_p1_r   <= {CELLS{1'b0}};
      board_p2_r   <= {CELLS{1'b0}};
      turn_r       <= 1'b0;
      starter_r    <= 1'b0;
      invalid_r    <= 1'b0;
      timeout_r    <= 1'b0;
      game_over_r  <= 1'b0;
      result_r     <= RES_NONE;
      move_count_r <= {CW{1'b0}};
      score_p1_r   <= {SCORE_W{1'b0}};
      score_p2_r   <= {SCORE_W{1'b0}};
      tcnt_r       <= {TW{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      board_p1_r   <= board_p1_nx_s;
      board_p2_r   <= board_p2_nx_s;
      turn_r       <= turn_nx_s;
      starter_r    <= starter_nx_s;
      invalid_r    <= invalid_nx_s;
      timeout_r    <= timeout_nx_s;
      game_over_r  <= (state_nx_s == DONE);
      result_r     <= result_nx_s;
      move_count_r <= move_count_nx_s;
      score_p1_r   <= score_p1_nx_s;
      score_p2_r   <= score_p2_nx_s;
      tcnt_r       <= tcnt_nx_s;
    end
  end

  assign board_p1   = board_p1_r;
  assign board_p2   = board_p2_r;
  assign turn       = turn_r;
  assign invalid    = invalid_r;
  assign timeout    = timeout_r;
  assign result     = result_r;
  assign game_over  = game_over_r;
  assign move_count = move_count_r;
  assign score_p1   = score_p1_r;
  assign score_p2   = score_p2_r;

endmodule

// File: tb/tb_ttt_game_engine.sv
// Bench for ttt_game_engine: 3x3 (no timeout, 2-bit scores) and 5x5/K=4
// (TIMEOUT=8) instances, a vector table, directed sequences and random play.
module tb_ttt_game_engine;

  logic clock = 1'b0;
  logic reset;

  bit in_rs[2];
  bit in_v[2];
  bit in_pl[2];
  int in_ix[2];

  logic a_rs, a_v, a_pl, a_turn, a_inv, a_to, a_over;
  logic [3:0] a_idx, a_cnt;
  logic [8:0] a_bp1, a_bp2;
  logic [1:0] a_res, a_s1, a_s2;

  logic b_rs, b_v, b_pl, b_turn, b_inv, b_to, b_over;
  logic [4:0] b_idx, b_cnt;
  logic [24:0] b_bp1, b_bp2;
  logic [1:0] b_res;
  logic [3:0] b_s1, b_s2;

  assign a_rs = in_rs[0];
  assign a_v = in_v[0];
  assign a_pl = in_pl[0];
  assign a_idx = 4'(in_ix[0]);
  assign b_rs = in_rs[1];
  assign b_v = in_v[1];
  assign b_pl = in_pl[1];
  assign b_idx = 5'(in_ix[1]);

  ttt_game_engine #(.N(3), .K(3), .TIMEOUT(0), .SCORE_W(2)) dut_a (
    .clock(clock), .reset(reset), .restart(a_rs), .move_valid(a_v),
    .move_player(a_pl), .move_idx(a_idx), .board_p1(a_bp1), .board_p2(a_bp2),
    .turn(a_turn), .invalid(a_inv), .timeout(a_to), .result(a_res),
    .game_over(a_over), .move_count(a_cnt), .score_p1(a_s1), .score_p2(a_s2));

  ttt_game_engine #(.N(5), .K(4), .TIMEOUT(8), .SCORE_W(4)) dut_b (
    .clock(clock), .reset(reset), .restart(b_rs), .move_valid(b_v),
    .move_player(b_pl), .move_idx(b_idx), .board_p1(b_bp1), .board_p2(b_bp2),
    .turn(b_turn), .invalid(b_inv), .timeout(b_to), .result(b_res),
    .game_over(b_over), .move_count(b_cnt), .score_p1(b_s1), .score_p2(b_s2));

  initial forever #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: cell ownership (0 free, 1 P1, 2 P2) plus game bookkeeping.
  int pn[2] = '{3, 5};
  int pk[2] = '{3, 4};
  int pt[2] = '{0, 8};
  int psmax[2] = '{3, 15};
  int own[2][32];
  int m_turn[2], m_start[2], m_phase[2], m_res[2], m_cnt[2], m_tcnt[2];
  int m_s1[2], m_s2[2], m_inv[2], m_to[2];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit has_run(int id, int p);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    int n = pn[id];
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          bit ok = 1'b1;
          for (int k = 0; k < pk[id]; k++) begin
            int rr = r + k * dr[d];
            int cc = c + k * dc[d];
            if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 1'b0;
            else if (own[id][rr*n+cc] != p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      for (int i = 0; i < 32; i++) own[id][i] = 0;
      m_turn[id] = 0; m_start[id] = 0; m_phase[id] = 0; m_res[id] = 0;
      m_cnt[id] = 0; m_tcnt[id] = 0; m_s1[id] = 0; m_s2[id] = 0;
      m_inv[id] = 0; m_to[id] = 0;
    end
  endtask

  task automatic model_step(int id);
    int cells = pn[id] * pn[id];
    bit acc;
    m_inv[id] = 0;
    m_to[id] = 0;
    if (in_rs[id]) begin
      for (int i = 0; i < 32; i++) own[id][i] = 0;
      m_cnt[id] = 0; m_res[id] = 0; m_tcnt[id] = 0;
      m_start[id] = 1 - m_start[id];
      m_turn[id] = m_start[id];
      m_phase[id] = 0;
    end else begin
      acc = (m_phase[id] == 0) && in_v[id] && (int'(in_pl[id]) == m_turn[id])
            && (in_ix[id] < cells) && (own[id][in_ix[id]] == 0);
      if (in_v[id] && !acc) m_inv[id] = 1;
      if (m_phase[id] == 0) begin
        if (acc) begin
          own[id][in_ix[id]] = m_turn[id] + 1;
          m_cnt[id]++;
          m_tcnt[id] = 0;
          m_phase[id] = 1;
        end else if (pt[id] > 0) begin
          if (m_tcnt[id] == pt[id] - 1) begin
            m_turn[id] = 1 - m_turn[id];
            m_to[id] = 1;
            m_tcnt[id] = 0;
          end else begin
            m_tcnt[id]++;
          end
        end
      end else if (m_phase[id] == 1) begin
        if (has_run(id, m_turn[id] + 1)) begin
          m_res[id] = m_turn[id] + 1;
          if (m_turn[id] == 0) m_s1[id] = (m_s1[id] < psmax[id]) ? m_s1[id] + 1 : m_s1[id];
          else m_s2[id] = (m_s2[id] < psmax[id]) ? m_s2[id] + 1 : m_s2[id];
          m_phase[id] = 2;
        end else if (m_cnt[id] == cells) begin
          m_res[id] = 3;
          m_phase[id] = 2;
        end else begin
          m_turn[id] = 1 - m_turn[id];
          m_phase[id] = 0;
        end
      end
    end
  endtask

  task automatic compare(int id);
    logic [24:0] mb1 = '0, mb2 = '0;
    logic [49:0] obs_b;
    logic [19:0] obs_s, exp_s;
    for (int i = 0; i < pn[id] * pn[id]; i++) begin
      mb1[i] = (own[id][i] == 1);
      mb2[i] = (own[id][i] == 2);
    end
    exp_s = {1'(m_turn[id]), 1'(m_inv[id]), 1'(m_to[id]), 2'(m_res[id]),
             1'(m_phase[id] == 2), 5'(m_cnt[id]), 4'(m_s1[id]), 4'(m_s2[id])};
    if (id == 0) begin
      obs_b = {25'(a_bp1), 25'(a_bp2)};
      obs_s = {a_turn, a_inv, a_to, a_res, a_over, 5'(a_cnt), 4'(a_s1), 4'(a_s2)};
      chk("model_a_boards", 64'(obs_b), 64'({mb1, mb2}));
      chk("model_a_status", 64'(obs_s), 64'(exp_s));
    end else begin
      obs_b = {b_bp1, b_bp2};
      obs_s = {b_turn, b_inv, b_to, b_res, b_over, b_cnt, b_s1, b_s2};
      chk("model_b_boards", 64'(obs_b), 64'({mb1, mb2}));
      chk("model_b_status", 64'(obs_s), 64'(exp_s));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic drive(int id, bit rs, bit v, bit pl, int ix);
    in_rs[id] = rs; in_v[id] = v; in_pl[id] = pl; in_ix[id] = ix;
  endtask

  task automatic mv(int id, bit pl, int ix);
    drive(id, 1'b0, 1'b1, pl, ix);
    tick();
    drive(id, 1'b0, 1'b0, 1'b0, 0);
    tick();
  endtask

  task automatic win_p1_game();
    drive(0, 1'b1, 1'b0, 1'b0, 0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 0);
    if (m_turn[0] == 1) begin
      mv(0, 1'b1, 6);
      mv(0, 1'b0, 0); mv(0, 1'b1, 3); mv(0, 1'b0, 1); mv(0, 1'b1, 4); mv(0, 1'b0, 2);
    end else begin
      mv(0, 1'b0, 0); mv(0, 1'b1, 3); mv(0, 1'b0, 1); mv(0, 1'b1, 4); mv(0, 1'b0, 2);
    end
  endtask

  typedef struct {
    bit v; bit pl; int ix;
    int p1; int p2; bit turn; bit inv; int res; bit over;
  } vec_t;

  function automatic vec_t mkv(bit v, bit pl, int ix, int p1, int p2,
                               bit turn, bit inv, int res, bit over);
    vec_t t;
    t.v = v; t.pl = pl; t.ix = ix; t.p1 = p1; t.p2 = p2;
    t.turn = turn; t.inv = inv; t.res = res; t.over = over;
    return t;
  endfunction

  vec_t tbl[14];
  int dm[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    tbl[0]  = mkv(1, 1, 0, 'h000, 'h000, 0, 1, 0, 0);
    tbl[1]  = mkv(1, 0, 0, 'h001, 'h000, 0, 0, 0, 0);
    tbl[2]  = mkv(1, 1, 5, 'h001, 'h000, 1, 1, 0, 0);
    tbl[3]  = mkv(1, 1, 3, 'h001, 'h008, 1, 0, 0, 0);
    tbl[4]  = mkv(0, 0, 0, 'h001, 'h008, 0, 0, 0, 0);
    tbl[5]  = mkv(1, 0, 3, 'h001, 'h008, 0, 1, 0, 0);
    tbl[6]  = mkv(1, 0, 9, 'h001, 'h008, 0, 1, 0, 0);
    tbl[7]  = mkv(1, 0, 1, 'h003, 'h008, 0, 0, 0, 0);
    tbl[8]  = mkv(0, 0, 0, 'h003, 'h008, 1, 0, 0, 0);
    tbl[9]  = mkv(1, 1, 4, 'h003, 'h018, 1, 0, 0, 0);
    tbl[10] = mkv(0, 0, 0, 'h003, 'h018, 0, 0, 0, 0);
    tbl[11] = mkv(1, 0, 2, 'h007, 'h018, 0, 0, 0, 0);
    tbl[12] = mkv(0, 0, 0, 'h007, 'h018, 0, 0, 1, 1);
    tbl[13] = mkv(1, 1, 5, 'h007, 'h018, 0, 1, 1, 1);

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 0);
    drive(1, 1'b0, 1'b0, 1'b0, 0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    chk("reset_state_a", 64'({a_bp1, a_bp2, a_turn, a_inv, a_to, a_res, a_over, a_cnt, a_s1, a_s2}), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(0, 1'b0, tbl[i].v, tbl[i].pl, tbl[i].ix);
      tick();
      chk($sformatf("vector_%0d", i), 64'({a_bp1, a_bp2, a_turn, a_inv, a_res, a_over}),
          64'({9'(tbl[i].p1), 9'(tbl[i].p2), tbl[i].turn, tbl[i].inv, 2'(tbl[i].res), tbl[i].over}));
    end
    drive(0, 1'b0, 1'b0, 1'b0, 0);
    chk("score_after_win", 64'({a_s1, a_s2}), 64'({2'd1, 2'd0}));

    drive(0, 1'b1, 1'b0, 1'b0, 0);
    tick();
    chk("restart_p2_starts", 64'({a_bp1, a_bp2, a_turn, a_res, a_over}), 64'({9'h000, 9'h000, 1'b1, 2'b00, 1'b0}));
    tick();
    chk("restart_p1_starts", 64'(a_turn), 64'(0));
    drive(0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 9; i++) mv(0, 1'(i % 2), dm[i]);
    chk("draw", 64'({a_res, a_over, a_s1, a_s2, a_cnt}), 64'({2'b11, 1'b1, 2'd1, 2'd0, 4'd9}));
    drive(0, 1'b1, 1'b0, 1'b0, 0);
    tick();
    chk("restart_after_draw", 64'({a_bp1, a_bp2, a_turn, a_over}), 64'({9'h000, 9'h000, 1'b1, 1'b0}));
    drive(0, 1'b1, 1'b1, 1'b1, 0);
    tick();
    chk("restart_with_move", 64'({a_bp1, a_bp2, a_inv, a_turn}), 64'({9'h000, 9'h000, 1'b0, 1'b0}));
    drive(0, 1'b0, 1'b0, 1'b0, 0);

    for (int w = 2; w <= 4; w++) begin
      win_p1_game();
      chk($sformatf("score_sat_%0d", w), 64'({a_res, a_s1}), 64'({2'b01, 2'(w < 3 ? w : 3)}));
    end

    drive(0, 1'b1, 1'b0, 1'b0, 0);
    tick();
    drive(0, 1'b0, 1'b1, 1'(m_turn[0]), 4);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset_a", 64'({a_bp1, a_bp2, a_turn, a_inv, a_res, a_over, a_cnt, a_s1, a_s2}), 64'(0));
    compare(0);
    compare(1);
    @(negedge clock);
    reset = 1'b0;
    drive(0, 1'b0, 1'b1, 1'b1, 0);
    tick();
    chk("p1_starts_after_reset", 64'({a_inv, a_turn, a_bp2}), 64'({1'b1, 1'b0, 9'h000}));
    drive(0, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      tick();
      chk("b_no_timeout", 64'(b_to), 64'(0));
    end
    tick();
    chk("b_timeout", 64'({b_to, b_turn}), 64'({1'b1, 1'b1}));
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("b_idle_after_timeout", 64'({b_to, b_turn}), 64'({1'b0, 1'b1}));
    end
    drive(1, 1'b0, 1'b1, 1'b1, 4);
    tick();
    chk("b_accept_at_limit", 64'({b_to, b_inv, b_bp2}), 64'({1'b0, 1'b0, 25'h0000010}));
    drive(1, 1'b0, 1'b0, 1'b0, 0);
    tick();
    mv(1, 1'b0, 0); mv(1, 1'b1, 8); mv(1, 1'b0, 1); mv(1, 1'b1, 12);
    mv(1, 1'b0, 2); mv(1, 1'b1, 16);
    chk("b_antidiag_win", 64'({b_res, b_over, b_s1, b_s2}), 64'({2'b10, 1'b1, 4'd0, 4'd1}));

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int id = 0; id < 2; id++) begin
        int cells = pn[id] * pn[id];
        bit rs = ($urandom_range(0, 99) < 4);
        bit v = 1'($urandom_range(0, 1));
        bit pl = ($urandom_range(0, 3) != 0) ? 1'(m_turn[id]) : 1'($urandom_range(0, 1));
        int ix = $urandom_range(0, cells + 4);
        drive(id, rs, v, pl, ix);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
